uart_receiver: RTL and testbench

Serial-to-parallel UART receiver for the 8N1 serial link, the receive end of the UART that shares the 16x-oversampling tick generator. It synchronizes the asynchronous serial input and detects the start-bit edge. On that edge it pulses `start_rx` so the tick generator realigns to mid-tick phase. It then samples each bit at its centre and presents the received byte through a valid/ack holding register, flagging framing, parity and overrun errors.

---
 rtl/uart_receiver.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_receiver.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Brief    : 16x-oversampled UART receiver with valid/ack holding register.
//            Define UART_RX_PARITY_EN to add an even-parity bit (8E1).
// Revision : 1.0  initial release
// ============================================================================
module uart_receiver #(
  parameter int DATA_BITS   = 8,
  parameter int SAMPLE_RATE = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic                 serial_in,
  output logic                 start_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 overrun
);

  localparam int c_bit_w  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int c_tick_w = (SAMPLE_RATE > 1) ? $clog2(SAMPLE_RATE) : 1;
  localparam logic [c_bit_w-1:0]  c_last_bit  = c_bit_w'(DATA_BITS - 1);
  localparam logic [c_tick_w-1:0] c_half_tick = c_tick_w'(SAMPLE_RATE / 2 - 1);
  localparam logic [c_tick_w-1:0] c_full_tick = c_tick_w'(SAMPLE_RATE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t               r_state, w_state_next;
  logic                 r_sync1, r_rx_s;
  logic [c_tick_w-1:0]  r_tick_cnt, w_tick_cnt_next;
  logic [c_bit_w-1:0]   r_bit_cnt, w_bit_cnt_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_start_rx, r_framing_error, r_overrun;
  logic                 w_start_rx, w_frame_done, w_framing_err;
`ifdef UART_RX_PARITY_EN
  logic                 r_parity_bit, w_parity_bit_next;
  logic                 r_parity_error, w_parity_err;
  logic                 w_parity_ok;

  // Even parity: data bits plus the parity bit must hold an even number of ones.
  assign w_parity_ok = ~(^{r_shift, r_parity_bit});
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
`ifdef UART_RX_PARITY_EN
      r_parity_bit <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_tick_cnt <= w_tick_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_shift    <= w_shift_next;
`ifdef UART_RX_PARITY_EN
      r_parity_bit <= w_parity_bit_next;
`endif
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_tick_cnt_next = r_tick_cnt;
    w_bit_cnt_next  = r_bit_cnt;
    w_shift_next    = r_shift;
    w_start_rx      = 1'b0;
    w_frame_done    = 1'b0;
    w_framing_err   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_parity_bit_next = r_parity_bit;
    w_parity_err      = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_start_rx      = 1'b1;
          w_tick_cnt_next = '0;
          w_state_next    = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (r_tick_cnt == c_half_tick) begin
            w_tick_cnt_next = '0;
            if (r_rx_s) begin
              w_state_next = S_IDLE;
            end else begin
              w_bit_cnt_next = '0;
              w_state_next   = S_DATA;
            end
          end else begin
            w_tick_cnt_next = r_tick_cnt + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (r_tick_cnt == c_full_tick) begin
            w_tick_cnt_next = '0;
            w_shift_next    = {r_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt == c_last_bit) begin
`ifdef UART_RX_PARITY_EN
              w_state_next = S_PARITY;
`else
              w_state_next = S_STOP;
`endif
            end else begin
              w_bit_cnt_next = r_bit_cnt + 1'b1;
            end
          end else begin
            w_tick_cnt_next = r_tick_cnt + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (r_tick_cnt == c_full_tick) begin
            w_tick_cnt_next   = '0;
            w_parity_bit_next = r_rx_s;
            w_state_next      = S_STOP;
          end else begin
            w_tick_cnt_next = r_tick_cnt + 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (r_tick_cnt == c_full_tick) begin
            w_tick_cnt_next = '0;
            if (r_rx_s) begin
`ifdef UART_RX_PARITY_EN
              if (w_parity_ok) w_frame_done = 1'b1;
              else             w_parity_err = 1'b1;
`else
              w_frame_done = 1'b1;
`endif
              w_state_next = S_IDLE;
            end else begin
              w_framing_err = 1'b1;
              w_state_next  = S_BREAK;
            end
          end else begin
            w_tick_cnt_next = r_tick_cnt + 1'b1;
          end
        end
      end
      // Hold here while the line stays low so a break is not seen as a new start.
      S_BREAK: begin
        if (r_rx_s) begin
          w_tick_cnt_next = '0;
          w_state_next    = S_IDLE;
        end
      end
      default: begin
        w_tick_cnt_next = '0;
        w_state_next    = S_IDLE;
      end
    endcase
  end

  // Synchronizer, holding register and registered one-cycle pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1         <= 1'b1;
      r_rx_s          <= 1'b1;
      r_rx_data       <= '0;
      r_rx_valid      <= 1'b0;
      r_start_rx      <= 1'b0;
      r_framing_error <= 1'b0;
      r_overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_error  <= 1'b0;
`endif
    end else begin
      r_sync1         <= serial_in;
      r_rx_s          <= r_sync1;
      r_start_rx      <= w_start_rx;
      r_framing_error <= w_framing_err;
      r_overrun       <= w_frame_done & r_rx_valid & ~rx_ack;
`ifdef UART_RX_PARITY_EN
      r_parity_error  <= w_parity_err;
`endif
      if (w_frame_done && (!r_rx_valid || rx_ack)) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (rx_ack) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign start_rx      = r_start_rx;
  assign rx_data       = r_rx_data;
  assign rx_valid      = r_rx_valid;
  assign framing_error = r_framing_error;
  assign overrun       = r_overrun;
`ifdef UART_RX_PARITY_EN
  assign parity_error  = r_parity_error;
`else
  assign parity_error  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_receiver
// Brief    : Directed self-checking bench for uart_receiver (8N1 / 8E1).
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_receiver;

  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = 16 * TICK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam int ACK_TICK = 8 + 16 * 8 + 16 + 16;
`else
  localparam int ACK_TICK = 8 + 16 * 8 + 16;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic       tick;
  logic       serial_in;
  logic       start_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       framing_error;
  logic       parity_error;
  logic       overrun;

  int n_checks = 0;
  int n_bad    = 0;
  int cyc      = 0;
  int fall_cyc = 0;
  int ack_req_cnt  = 0;
  int ack_done_cnt = 0;
  int ack_at_tick  = 0;
  int phase        = 0;
  int ntick        = 0;
  logic do_ack;
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  int n_start = 0, n_ferr = 0, n_perr = 0, n_ovr = 0, n_vrise = 0;
  int last_start_cyc = 0;
  logic prev_valid = 1'b0;

  uart_receiver #(.DATA_BITS(8), .SAMPLE_RATE(16)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .tick          (tick),
    .serial_in     (serial_in),
    .start_rx      (start_rx),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ack        (rx_ack),
    .framing_error (framing_error),
    .parity_error  (parity_error),
    .overrun       (overrun)
  );

  initial forever #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Tick generator that realigns on start_rx; also owns rx_ack.
  initial begin
    tick = 1'b0;
    rx_ack = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (start_rx) begin
        phase = 0;
        ntick = 0;
      end else begin
        phase = (phase == TICK_DIV - 1) ? 0 : phase + 1;
      end
      tick = (phase == TICK_DIV - 1);
      if (tick) ntick++;
      do_ack = 1'b0;
      if (ack_req_cnt != ack_done_cnt) begin
        do_ack = 1'b1;
        ack_done_cnt++;
      end
      if (tick && ack_at_tick != 0 && ntick == ack_at_tick) do_ack = 1'b1;
      rx_ack = do_ack;
    end
  end

  always @(negedge clock) begin
    if (start_rx) begin
      n_start <= n_start + 1;
      last_start_cyc <= cyc;
    end
    if (framing_error) n_ferr <= n_ferr + 1;
    if (parity_error) n_perr <= n_perr + 1;
    if (overrun) n_ovr <= n_ovr + 1;
    if (rx_valid && !prev_valid) n_vrise <= n_vrise + 1;
    prev_valid <= rx_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic hold_line(input logic b, input int nclk);
    serial_in = b;
    repeat (nclk) begin @(posedge clock); #1; end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stopb);
    fall_cyc = cyc;
    hold_line(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) hold_line(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
    hold_line((^d) ^ par_flip, BIT_CLKS);
`endif
    hold_line(stopb, BIT_CLKS);
  endtask

  task automatic pulse_ack();
    ack_req_cnt++;
    repeat (4) begin @(posedge clock); #1; end
  endtask

  task automatic test_reset();
    serial_in = 1'b1;
    reset_n = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    n_checks++; if (start_rx !== 1'b0) begin n_bad++; $display("FAIL reset_start_rx: got %b want 0", start_rx); end
    n_checks++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    n_checks++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    n_checks++; if ({framing_error, parity_error, overrun} !== 3'b000) begin
      n_bad++; $display("FAIL reset_errors: got %b want 000", {framing_error, parity_error, overrun});
    end
    reset_n = 1'b1;
    hold_line(1'b1, 2 * BIT_CLKS);
    n_checks++; if (n_start !== 0) begin n_bad++; $display("FAIL reset_idle_start: got %0d want 0", n_start); end
  endtask

  task automatic test_clean_byte();
    int s0, f0, o0, v0;
    s0 = n_start; f0 = n_ferr; o0 = n_ovr; v0 = n_vrise;
    send_frame(8'hA5, 1'b1);
    hold_line(1'b1, BIT_CLKS);
    n_checks++; if (n_start - s0 !== 1) begin n_bad++; $display("FAIL clean_start_count: got %0d want 1", n_start - s0); end
    n_checks++; if (last_start_cyc - fall_cyc !== 3) begin
      n_bad++; $display("FAIL clean_start_latency: got %0d want 3", last_start_cyc - fall_cyc);
    end
    n_checks++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL clean_valid: got %b want 1", rx_valid); end
    n_checks++; if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL clean_data: got %h want a5", rx_data); end
    n_checks++; if (n_vrise - v0 !== 1) begin n_bad++; $display("FAIL clean_valid_rise: got %0d want 1", n_vrise - v0); end
    n_checks++; if ((n_ferr - f0) + (n_ovr - o0) !== 0) begin
      n_bad++; $display("FAIL clean_errors: got %0d want 0", (n_ferr - f0) + (n_ovr - o0));
    end
    pulse_ack();
    n_checks++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL ack_clears_valid: got %b want 0", rx_valid); end
    pulse_ack();
    n_checks++; if (rx_valid !== 1'b0 || rx_data !== 8'hA5) begin
      n_bad++; $display("FAIL ack_when_empty: got valid=%b data=%h want valid=0 data=a5", rx_valid, rx_data);
    end
  endtask

  task automatic test_false_start();
    int s0, f0;
    s0 = n_start; f0 = n_ferr;
    hold_line(1'b0, 4 * TICK_DIV);
    hold_line(1'b1, 2 * BIT_CLKS);
    n_checks++; if (n_start - s0 !== 1) begin n_bad++; $display("FAIL false_start_pulse: got %0d want 1", n_start - s0); end
    n_checks++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL false_start_valid: got %b want 0", rx_valid); end
    send_frame(8'h3C, 1'b1);
    hold_line(1'b1, BIT_CLKS);
    n_checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
      n_bad++; $display("FAIL after_false_start: got valid=%b data=%h want valid=1 data=3c", rx_valid, rx_data);
    end
    n_checks++; if (n_ferr - f0 !== 0) begin n_bad++; $display("FAIL false_start_ferr: got %0d want 0", n_ferr - f0); end
    pulse_ack();
  endtask

  task automatic test_framing();
    int s0, f0;
    s0 = n_start; f0 = n_ferr;
    send_frame(8'h55, 1'b0);
    hold_line(1'b0, 3 * BIT_CLKS);
    n_checks++; if (n_ferr - f0 !== 1) begin n_bad++; $display("FAIL framing_pulse: got %0d want 1", n_ferr - f0); end
    n_checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h3C) begin
      n_bad++; $display("FAIL framing_holding: got valid=%b data=%h want valid=0 data=3c", rx_valid, rx_data);
    end
    n_checks++; if (n_start - s0 !== 1) begin n_bad++; $display("FAIL framing_no_retrigger: got %0d want 1", n_start - s0); end
    hold_line(1'b1, 2 * BIT_CLKS);
    n_checks++; if (n_start - s0 !== 1) begin n_bad++; $display("FAIL framing_release: got %0d want 1", n_start - s0); end
  endtask

  task automatic test_parity();
`ifdef UART_RX_PARITY_EN
    int p0;
    p0 = n_perr;
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    hold_line(1'b1, BIT_CLKS);
    n_checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h07) begin
      n_bad++; $display("FAIL parity_good: got valid=%b data=%h want valid=1 data=07", rx_valid, rx_data);
    end
    n_checks++; if (n_perr - p0 !== 0) begin n_bad++; $display("FAIL parity_good_err: got %0d want 0", n_perr - p0); end
    pulse_ack();
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    hold_line(1'b1, BIT_CLKS);
    par_flip = 1'b0;
    n_checks++; if (n_perr - p0 !== 1) begin n_bad++; $display("FAIL parity_bad_pulse: got %0d want 1", n_perr - p0); end
    n_checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h07) begin
      n_bad++; $display("FAIL parity_bad_holding: got valid=%b data=%h want valid=0 data=07", rx_valid, rx_data);
    end
`else
    send_frame(8'h07, 1'b1);
    hold_line(1'b1, BIT_CLKS);
    n_checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h07) begin
      n_bad++; $display("FAIL no_parity_frame: got valid=%b data=%h want valid=1 data=07", rx_valid, rx_data);
    end
    pulse_ack();
`endif
  endtask

  task automatic test_overrun_ack();
    int o0;
    send_frame(8'h11, 1'b1);
    hold_line(1'b1, BIT_CLKS);
    n_checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      n_bad++; $display("FAIL overrun_first: got valid=%b data=%h want valid=1 data=11", rx_valid, rx_data);
    end
    o0 = n_ovr;
    send_frame(8'h22, 1'b1);
    hold_line(1'b1, BIT_CLKS);
    n_checks++; if (n_ovr - o0 !== 1) begin n_bad++; $display("FAIL overrun_pulse: got %0d want 1", n_ovr - o0); end
    n_checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      n_bad++; $display("FAIL overrun_keep: got valid=%b data=%h want valid=1 data=11", rx_valid, rx_data);
    end
    pulse_ack();
    n_checks++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL overrun_ack: got %b want 0", rx_valid); end
    send_frame(8'h11, 1'b1);
    hold_line(1'b1, BIT_CLKS);
    o0 = n_ovr;
    ack_at_tick = ACK_TICK;
    send_frame(8'h22, 1'b1);
    ack_at_tick = 0;
    hold_line(1'b1, BIT_CLKS);
    n_checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h22) begin
      n_bad++; $display("FAIL coincident_ack: got valid=%b data=%h want valid=1 data=22", rx_valid, rx_data);
    end
    n_checks++; if (n_ovr - o0 !== 0) begin n_bad++; $display("FAIL coincident_overrun: got %0d want 0", n_ovr - o0); end
  endtask

  task automatic test_reset_mid_frame();
    hold_line(1'b0, 5 * BIT_CLKS);
    hold_line(1'b1, BIT_CLKS / 2);
    reset_n = 1'b0;
    #1;
    n_checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
      n_bad++; $display("FAIL midreset_holding: got valid=%b data=%h want valid=0 data=00", rx_valid, rx_data);
    end
    n_checks++; if ({start_rx, framing_error, parity_error, overrun} !== 4'b0000) begin
      n_bad++; $display("FAIL midreset_pulses: got %b want 0000", {start_rx, framing_error, parity_error, overrun});
    end
    hold_line(1'b1, 2 * BIT_CLKS);
    reset_n = 1'b1;
    hold_line(1'b1, BIT_CLKS);
    send_frame(8'hF0, 1'b1);
    hold_line(1'b1, BIT_CLKS);
    n_checks++; if (rx_valid !== 1'b1 || rx_data !== 8'hF0) begin
      n_bad++; $display("FAIL after_midreset: got valid=%b data=%h want valid=1 data=f0", rx_valid, rx_data);
    end
  endtask

  initial begin
    serial_in = 1'b1;
    reset_n   = 1'b0;
    test_reset();
    test_clean_byte();
    test_false_start();
    test_framing();
    test_parity();
    test_overrun_ack();
    test_reset_mid_frame();
`ifndef UART_RX_PARITY_EN
    n_checks++; if (n_perr !== 0) begin n_bad++; $display("FAIL parity_tied_low: got %0d want 0", n_perr); end
`endif
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
